// File: rtl/inv_stim_checker.sv
// Clocked stimulus/response checker for an inverter DUT: drives 1,0,1,... and samples the response SETTLE_CYCLES later.
// Reports a verdict per vector, keeps saturating pass/fail counts and pulses done after the last vector.
module inv_stim_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VECTORS   = 2,
    parameter int IDX_W         = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_y,
    output logic             stim,
    output logic             busy,
    output logic             result_valid,
    output logic             result_pass,
    output logic [IDX_W-1:0] vec_idx,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             done
);
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] settle_cnt;
    logic            last_vec;
    logic            verdict;
    logic            cancel;

    assign last_vec = (vec_idx == IDX_LAST);
    assign verdict  = (dut_y == ~stim);
    assign cancel   = abort && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == SC_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = last_vec ? IDLE : DRIVE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything, including a CHECK verdict in the same cycle.
        if (cancel) state_nxt = IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim         <= 1'b0;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            done         <= 1'b0;
            vec_idx      <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            settle_cnt   <= '0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            if (cancel) begin
                stim <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        vec_idx  <= '0;
                        pass_cnt <= '0;
                        fail_cnt <= '0;
                    end
                    DRIVE: begin
                        stim       <= ~vec_idx[0];
                        settle_cnt <= '0;
                    end
                    SETTLE: settle_cnt <= settle_cnt + 1'b1;
                    CHECK: begin
                        result_valid <= 1'b1;
                        result_pass  <= verdict;
                        if (verdict) begin
                            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                        end
                        if (last_vec) done    <= 1'b1;
                        else          vec_idx <= vec_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inv_stim_checker.sv
// Bench for inv_stim_checker: table-driven and randomized runs against a per-vector reference model,
// plus hand-written abort, reset and counter-saturation sequences.
module tb_inv_stim_checker;
    localparam int S = 4;
    localparam int N = 2;
    localparam int P = S + 2;

    logic       clk;
    logic       rst_n, start, abort, dut_y;
    logic       stim, busy, result_valid, result_pass, done;
    logic [3:0] vec_idx;
    logic [7:0] pass_cnt, fail_cnt;

    logic       s_start, s_dut_y, s_stim, s_busy, s_rv, s_rp, s_done;
    logic [2:0] s_vec_idx;
    logic [1:0] s_pass, s_fail;

    int   mode;
    logic glitch_en, noise;
    bit   model_stim;
    int   tests, fails;

    typedef struct {
        int mode;
        bit glitchy;
        int exp_pass;
        int exp_fail;
    } vec_t;
    vec_t tbl[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DUT: 0 inverter, 1 buffer, 2 stuck-at-0, 3 stuck-at-1.
    function automatic logic dut_fn(input int m, input logic s);
        case (m)
            0:       return ~s;
            1:       return s;
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int vec_ok(input int m, input int i);
        logic s;
        s = (i % 2 == 0);
        return int'(dut_fn(m, s) == !s);
    endfunction

    assign dut_y   = glitch_en ? noise : dut_fn(mode, stim);
    assign s_dut_y = ~s_stim;

    inv_stim_checker #(.SETTLE_CYCLES(S), .NUM_VECTORS(N), .IDX_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(dut_y),
        .stim(stim), .busy(busy), .result_valid(result_valid), .result_pass(result_pass),
        .vec_idx(vec_idx), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .done(done)
    );

    inv_stim_checker #(.SETTLE_CYCLES(1), .NUM_VECTORS(5), .IDX_W(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .dut_y(s_dut_y),
        .stim(s_stim), .busy(s_busy), .result_valid(s_rv), .result_pass(s_rp),
        .vec_idx(s_vec_idx), .pass_cnt(s_pass), .fail_cnt(s_fail), .done(s_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller has already driven start=1 before the accepting edge (edge 0).
    // Every output is compared after each edge against what the vector rules predict.
    task automatic run_vectors(input bit glitchy, input bit repulse, input bit chain,
                               output int np, output int nf);
        int  exp_pass, exp_fail, idx;
        bit  rv;
        exp_pass = 0;
        exp_fail = 0;
        for (int e = 0; e <= N * P; e++) begin
            @(posedge clk);
            @(negedge clk);
            rv = (e > 0) && (e % P == 0);
            if (rv) begin
                if (vec_ok(mode, e / P - 1) != 0) exp_pass++;
                else                              exp_fail++;
            end
            idx = (e / P < N) ? e / P : N - 1;
            if (e >= 1) model_stim = (((e - 1) / P) % 2 == 0);
            chk("busy", int'(busy), int'(e < N * P));
            chk("result_valid", int'(result_valid), int'(rv));
            if (rv) chk("result_pass", int'(result_pass), vec_ok(mode, e / P - 1));
            chk("done", int'(done), int'(e == N * P));
            chk("vec_idx", int'(vec_idx), idx);
            chk("pass_cnt", int'(pass_cnt), exp_pass);
            chk("fail_cnt", int'(fail_cnt), exp_fail);
            chk("stim", int'(stim), int'(model_stim));
            glitch_en = glitchy && (e % P != P - 1);
            noise     = 1'($urandom % 2);
            if (e == N * P) start = chain;
            else            start = repulse && ($urandom % 3 == 0);
        end
        np = exp_pass;
        nf = exp_fail;
    endtask

    initial begin
        int  np, nf, rv_cnt, done_cnt, done_at, rv_at_done;
        bit  chained;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0;
        mode = 0; glitch_en = 1'b0; noise = 1'b0; model_stim = 1'b0;

        tbl[0] = '{0, 1'b0, 2, 0};
        tbl[1] = '{1, 1'b0, 0, 2};
        tbl[2] = '{2, 1'b1, 1, 1};
        tbl[3] = '{3, 1'b1, 1, 1};

        #12;
        chk("rst_stim", int'(stim), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_rp", int'(result_pass), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(vec_idx), 0);
        chk("rst_pass", int'(pass_cnt), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        chk("rst_sat_busy", int'(s_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; the buffer run chains straight into stuck-at-0 via start on the done cycle.
        chained = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!chained) begin
                @(negedge clk);
                start = 1'b1;
            end
            mode = tbl[i].mode;
            run_vectors(tbl[i].glitchy, 1'b0, (i == 1), np, nf);
            chained = (i == 1);
            chk("tbl_pass", int'(pass_cnt), tbl[i].exp_pass);
            chk("tbl_fail", int'(fail_cnt), tbl[i].exp_fail);
            chk("tbl_model_pass", np, tbl[i].exp_pass);
        end

        // Start re-pulsed during SETTLE, then abort during SETTLE of vector 1.
        @(negedge clk);
        mode = 0; glitch_en = 1'b0; start = 1'b1;
        for (int e = 0; e <= P + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = (e == 2);
        end
        chk("repulse_idx", int'(vec_idx), 1);
        chk("repulse_pass", int'(pass_cnt), 1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        model_stim = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_stim", int'(stim), 0);
        chk("abort_rv", int'(result_valid), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass_cnt), 1);
        chk("abort_idx", int'(vec_idx), 1);
        done_cnt = 0;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort_quiet", done_cnt, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_pass", int'(pass_cnt), 1);

        // Abort in the CHECK cycle suppresses the verdict.
        start = 1'b1;
        for (int e = 0; e < P; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_chk_rv", int'(result_valid), 0);
        chk("abort_chk_pass", int'(pass_cnt), 0);
        chk("abort_chk_busy", int'(busy), 0);
        chk("abort_chk_stim", int'(stim), 0);

        // Asynchronous reset in the CHECK cycle, then a clean run.
        start = 1'b1;
        for (int e = 0; e < P; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_stim", int'(stim), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stim", int'(stim), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_rv", int'(result_valid), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_idx", int'(vec_idx), 0);
        chk("arst_pass", int'(pass_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_stim = 1'b0;
        @(negedge clk);
        start = 1'b1;
        run_vectors(1'b0, 1'b0, 1'b0, np, nf);
        chk("post_rst_pass", int'(pass_cnt), 2);

        // Randomized runs: random DUT behaviour, settle-time glitches and ignored start pulses.
        for (int r = 0; r < 20; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            @(negedge clk);
            mode  = int'($urandom % 4);
            start = 1'b1;
            run_vectors(1'($urandom % 2), 1'b1, 1'b0, np, nf);
            chk("rand_total", np + nf, N);
        end
        glitch_en = 1'b0;

        // Saturation with a 2-bit counter, 5 vectors, single settle cycle.
        @(negedge clk);
        s_start = 1'b1;
        rv_cnt = 0; done_cnt = 0; done_at = -1; rv_at_done = 0;
        for (int e = 0; e < 60 && done_cnt == 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            s_start = 1'b0;
            if (s_rv) rv_cnt++;
            if (s_done) begin
                done_cnt++;
                done_at    = e;
                rv_at_done = int'(s_rv);
            end
        end
        chk("sat_done_seen", done_cnt, 1);
        chk("sat_done_edge", done_at, 15);
        chk("sat_done_with_rv", rv_at_done, 1);
        chk("sat_rv_count", rv_cnt, 5);
        chk("sat_pass", int'(s_pass), 3);
        chk("sat_fail", int'(s_fail), 0);
        chk("sat_idx", int'(s_vec_idx), 4);
        chk("sat_busy", int'(s_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/inv_stim_checker.md
Name: inv_stim_checker

Overview:
- Synthesizable stimulus/response engine for the inverter exercise: drives a single-bit stimulus into the device under test and samples its single-bit response after a programmable settle time.
- Checks each response against the expected inversion, counts passes and failures, and reports a per-vector result and an end-of-run done pulse.
- Sits beside the student design in the hardware self-test wrapper, where it replaces the delay-based bench with a clocked, cycle-deterministic checker.

Parameters:
- SETTLE_CYCLES, 4: cycles between driving the stimulus and sampling the response. Legal range is 1 or more; 0 is illegal.
- NUM_VECTORS, 2: vectors per run. Legal range is 1 to 2**IDX_W.
- IDX_W, 4: width of the vector index.
- CNT_W, 8: width of the pass and fail counters.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: run request, sampled only in IDLE.
- abort, input, 1: synchronous run cancel.
- dut_y, input, 1: DUT response, same clock domain, sampled only in CHECK.
- stim, output, 1: registered stimulus driven to the DUT input.
- busy, output, 1: high in DRIVE, SETTLE and CHECK.
- result_valid, output, 1: one-cycle pulse per checked vector.
- result_pass, output, 1: verdict for the vector; valid while result_valid is high.
- vec_idx, output, IDX_W: index of the current or last-checked vector.
- pass_cnt, output, CNT_W: saturating pass count.
- fail_cnt, output, CNT_W: saturating fail count.
- done, output, 1: one-cycle pulse after the last vector is checked.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stim, busy, result_valid, result_pass, done = 0; vec_idx, pass_cnt, fail_cnt = 0. Reset mid-run aborts the run immediately with no done pulse.
- States: IDLE, DRIVE, SETTLE, CHECK.
- Stimulus pattern: vector i drives stim = ~i[0], giving 1, 0, 1, 0, ... Expected response for every vector is dut_y = ~stim.
- IDLE:
  - On the edge where start=1: go to DRIVE, clear vec_idx, pass_cnt and fail_cnt to 0, set busy=1.
  - start=0: remain in IDLE.
- DRIVE (1 cycle): stim <= ~vec_idx[0]; settle counter <= 0; go to SETTLE.
- SETTLE (exactly SETTLE_CYCLES cycles): counter increments each cycle; at count SETTLE_CYCLES-1, go to CHECK.
- CHECK (1 cycle): compare dut_y with ~stim. On the exiting edge:
  - result_valid <= 1 and result_pass <= (dut_y == ~stim).
  - Increment pass_cnt or fail_cnt; each counter saturates at 2**CNT_W-1.
  - If vec_idx == NUM_VECTORS-1: go to IDLE, done <= 1, busy <= 0, vec_idx holds, stim holds its last value.
  - Otherwise: vec_idx++ and go to DRIVE.
- Latency:
  - First result_valid rises 2+SETTLE_CYCLES edges after the edge that accepts start.
  - Each vector takes 2+SETTLE_CYCLES cycles.
  - done coincides with the final result_valid.
- result_valid and done are single-cycle pulses and are 0 in all other cycles.
- start while busy is ignored and not queued.
- start in the same cycle as the done pulse is accepted, because the state is already IDLE on the following edge; this allows back-to-back runs.
- abort=1 in any non-IDLE state:
  - Next edge: state=IDLE, busy=0, stim=0.
  - No result_valid or done that cycle; counters and vec_idx hold.
  - abort in IDLE has no effect. abort has priority over the CHECK result when both occur in the same cycle.
- dut_y is ignored outside CHECK; glitches during SETTLE do not matter.

Test Plan:
- Correct inverter (dut_y = ~stim), S=4, N=2, start pulse:
  - stim=1 then 0.
  - result_valid at +6 and +12 edges, result_pass=1 both times.
  - pass_cnt=2, fail_cnt=0, done coincides with the 2nd result_valid.
- Buffer DUT (dut_y = stim):
  - Two fails, result_pass=0 both times.
  - fail_cnt=2, pass_cnt=0, done=1 once.
- Stuck-at-0 DUT:
  - Vector 0 (stim=1, expect 0) passes; vector 1 (stim=0, expect 1) fails.
  - pass_cnt=1, fail_cnt=1.
- Control abuse and abort:
  - start re-pulsed during SETTLE: no restart, counters unaffected.
  - abort during SETTLE of vector 1: IDLE next edge, stim=0, busy=0, no done, pass_cnt stays 1.
- Reset and saturation:
  - rst_n dropped mid-CHECK: all outputs 0 immediately (asynchronous); release rst_n, start, and a full run completes normally.
  - Saturation: CNT_W=2, N=5, correct DUT gives pass_cnt=3 (saturated) and done after 5 result_valid pulses.
